// File: rtl/bios_watchdog.sv
// BIOS boot watchdog: times the boot, swaps flash image on timeout,
// requests a platform reset, and reports status to the LPC block.
module bios_watchdog #(
  parameter int CLK_PER_MS    = 33333,
  parameter int TIMEOUT_MS    = 30000,
  parameter int RST_PULSE_CYC = 1024
) (
  input  logic       LpcClock,
  input  logic       PciReset,
  input  logic       WriteBiosWD,
  input  logic [7:0] BiosRegister,
  output logic [2:0] BiosStatus,
  output logic       BiosSel,
  output logic       SysResetReq,
  output logic       WdtExpired
);

  typedef enum logic [1:0] {
    ARMED  = 2'd0,
    RST    = 2'd1,
    DONE   = 2'd2,
    FAILED = 2'd3
  } state_t;

  localparam logic [15:0] PRE_TC = 16'(CLK_PER_MS - 1);
  localparam logic [15:0] MS_TC  = 16'(TIMEOUT_MS - 1);
  localparam logic [15:0] PLS_TC = 16'(RST_PULSE_CYC - 1);

  state_t      state;
  logic        wr_dly;
  logic        attempt;
  logic [15:0] pre;
  logic [15:0] ms;
  logic [15:0] pls;

  logic post;
  logic force_arm;
  logic kick;
  logic ms_tick;
  logic expiry;
  logic unused;

  assign unused = ^BiosRegister[7:3];

  // PostDone > ForceArm > Kick
  always_comb begin
    post      = wr_dly & BiosRegister[0];
    force_arm = wr_dly & BiosRegister[2] & ~BiosRegister[0];
    kick      = wr_dly & BiosRegister[1]
              & ~BiosRegister[2] & ~BiosRegister[0];
    ms_tick   = (pre == PRE_TC);
    expiry    = ms_tick & (ms == MS_TC);
  end

  always_ff @(posedge LpcClock) begin
    if (PciReset) begin
      state       <= ARMED;
      wr_dly      <= 1'b0;
      attempt     <= 1'b0;
      pre         <= '0;
      ms          <= '0;
      pls         <= '0;
      BiosSel     <= 1'b0;
      SysResetReq <= 1'b0;
      WdtExpired  <= 1'b0;
      BiosStatus  <= 3'b001;
    end else begin
      // strobes landing in RST are dropped, not deferred
      wr_dly     <= WriteBiosWD & (state != RST);
      WdtExpired <= 1'b0;
      unique case (state)
        ARMED: begin
          if (post) begin
            state      <= DONE;
            pre        <= '0;
            ms         <= '0;
            BiosStatus <= {1'b0, BiosSel, 1'b0};
          end else if (force_arm | kick) begin
            pre <= '0;
            ms  <= '0;
          end else if (expiry) begin
            pre        <= '0;
            ms         <= '0;
            WdtExpired <= 1'b1;
            if (!attempt) begin
              attempt     <= 1'b1;
              BiosSel     <= ~BiosSel;
              SysResetReq <= 1'b1;
              state       <= RST;
              BiosStatus  <= {1'b0, ~BiosSel, 1'b0};
            end else begin
              state      <= FAILED;
              BiosStatus <= {1'b1, BiosSel, 1'b0};
            end
          end else if (ms_tick) begin
            pre <= '0;
            ms  <= ms + 16'd1;
          end else begin
            pre <= pre + 16'd1;
          end
        end
        RST: begin
          if (pls == PLS_TC) begin
            pls         <= '0;
            SysResetReq <= 1'b0;
            state       <= ARMED;
            BiosStatus  <= {1'b0, BiosSel, 1'b1};
          end else begin
            pls <= pls + 16'd1;
          end
        end
        DONE, FAILED: begin
          if (post) begin
            state      <= DONE;
            BiosStatus <= {1'b0, BiosSel, 1'b0};
          end else if (force_arm) begin
            state      <= ARMED;
            attempt    <= 1'b0;
            pre        <= '0;
            ms         <= '0;
            BiosStatus <= {1'b0, BiosSel, 1'b1};
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bios_watchdog.sv
// Bench for bios_watchdog: directed boot scenarios plus random
// command traffic against a cycle-count reference model.
module tb_bios_watchdog;

  localparam int CPM   = 4;
  localparam int TMS   = 5;
  localparam int RPC   = 3;
  localparam int TOTAL = CPM * TMS;

  logic       clk  = 1'b0;
  logic       prst = 1'b1;
  logic       wr   = 1'b0;
  logic [7:0] regv = 8'h00;
  logic [2:0] status;
  logic       sel;
  logic       sreq;
  logic       wexp;

  bios_watchdog #(
    .CLK_PER_MS(CPM),
    .TIMEOUT_MS(TMS),
    .RST_PULSE_CYC(RPC)
  ) dut (
    .LpcClock(clk),
    .PciReset(prst),
    .WriteBiosWD(wr),
    .BiosRegister(regv),
    .BiosStatus(status),
    .BiosSel(sel),
    .SysResetReq(sreq),
    .WdtExpired(wexp)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(string tag, logic [31:0] got,
                       logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h at %0t",
                  tag, got, exp, $time);
  endtask

  // reference model: whole-cycle budget instead of split counters
  typedef enum {M_ARM, M_RST, M_DONE, M_FAIL} mst_t;
  mst_t mst = M_ARM;
  int   elapsed = 0;
  int   rst_left = 0;
  bit   attempt = 0;
  bit   msel = 0;
  bit   mexp = 0;
  bit   pend = 0;
  bit   mvalid = 0;

  always @(posedge clk) begin
    bit nxt;
    if (prst) begin
      mst = M_ARM; elapsed = 0; rst_left = 0;
      attempt = 0; msel = 0; mexp = 0; pend = 0;
      mvalid = 1;
    end else begin
      nxt  = wr && (mst != M_RST);
      mexp = 0;
      case (mst)
        M_ARM:
          if (pend && regv[0]) mst = M_DONE;
          else if (pend && (regv[1] || regv[2])) elapsed = 0;
          else begin
            elapsed++;
            if (elapsed == TOTAL) begin
              elapsed = 0;
              mexp = 1;
              if (!attempt) begin
                attempt = 1; msel = !msel;
                mst = M_RST; rst_left = RPC;
              end else mst = M_FAIL;
            end
          end
        M_RST: begin
          rst_left--;
          if (rst_left == 0) begin
            mst = M_ARM; elapsed = 0;
          end
        end
        default:
          if (pend && regv[0]) mst = M_DONE;
          else if (pend && regv[2]) begin
            mst = M_ARM; attempt = 0; elapsed = 0;
          end
      endcase
      pend = nxt;
    end
  end

  int n_exp = 0;
  always @(negedge clk) begin
    if (wexp) n_exp++;
    if (mvalid)
      check("cycle", {status, sel, sreq, wexp},
            {(mst == M_FAIL), msel, (mst == M_ARM),
             msel, (mst == M_RST), mexp});
  end

  int cyc = 0;

  task automatic to_cycle(int k);
    repeat (k - cyc) @(negedge clk);
    cyc = k;
  endtask

  task automatic write(logic [7:0] v);
    regv = v;
    wr   = 1'b1;
    @(negedge clk);
    wr   = 1'b0;
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    prst = 1'b1;
    wr   = 1'b0;
    repeat (2) @(negedge clk);
    prst = 1'b0;
    cyc  = 0;
  endtask

  initial begin
    int e0;
    int gap;
    logic [7:0] v;
    logic [7:0] tbl [10];
    tbl = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04,
            8'h05, 8'h06, 8'h07, 8'hF8, 8'hFA};

    // idle boot: two expiries, then FAILED
    do_reset();
    check("rst_status", status, 3'b001);
    check("rst_sreq", sreq, 0);
    to_cycle(19); check("pre_exp", wexp, 0);
    to_cycle(20);
    check("exp1", wexp, 1);
    check("sel_swap", sel, 1);
    check("sreq_on", sreq, 1);
    check("rst_stat", status, 3'b010);
    to_cycle(22); check("sreq_last", sreq, 1);
    to_cycle(23);
    check("sreq_off", sreq, 0);
    check("rearm", status, 3'b011);
    to_cycle(42); check("pre_exp2", wexp, 0);
    to_cycle(43);
    check("exp2", wexp, 1);
    check("failed", status, 3'b110);
    check("no_sreq2", sreq, 0);
    to_cycle(60); check("fail_hold", status, 3'b110);

    // ForceArm out of FAILED, then reset mid-pulse
    write(8'h04);
    to_cycle(62); check("forcearm", status, 3'b011);
    to_cycle(81); check("fa_pre", wexp, 0);
    to_cycle(82);
    check("fa_exp", wexp, 1);
    check("fa_sel", sel, 0);
    check("fa_sreq", sreq, 1);
    prst = 1'b1;
    to_cycle(84);
    prst = 1'b0;
    check("trunc_sreq", sreq, 0);
    check("trunc_stat", status, 3'b001);
    to_cycle(103); check("rs_pre", wexp, 0);
    to_cycle(104);
    check("rs_exp", wexp, 1);
    check("rs_sel", sel, 1);

    // periodic kicks keep the watchdog quiet
    do_reset();
    e0 = n_exp;
    for (int k = 0; k < 7; k++) begin
      to_cycle(15 * k);
      write(8'h02);
    end
    to_cycle(100);
    check("kick_noexp", n_exp - e0, 0);
    check("kick_stat", status, 3'b001);

    // PostDone stops timing; later Kick ignored
    do_reset();
    to_cycle(10); write(8'h01);
    to_cycle(11); check("pd_lat", status, 3'b001);
    to_cycle(12); check("pd_done", status, 3'b000);
    e0 = n_exp;
    to_cycle(212); check("pd_noexp", n_exp - e0, 0);
    write(8'h02);
    to_cycle(216); check("pd_kick", status, 3'b000);

    // command lands on the expiry tick
    do_reset();
    to_cycle(18); write(8'h03);
    to_cycle(20);
    check("race_stat", status, 3'b000);
    check("race_exp", wexp, 0);
    check("race_sel", sel, 0);
    e0 = n_exp;
    to_cycle(40); check("race_quiet", n_exp - e0, 0);

    // random traffic; model checks every cycle
    do_reset();
    gap = 10;
    repeat (3000) begin
      @(negedge clk);
      gap++;
      wr   = 1'b0;
      prst = 1'b0;
      if (gap >= 2 && $urandom_range(0, 19) == 0) begin
        v = tbl[$urandom_range(0, 9)];
        if (mst == M_ARM && v[2] && !v[0]) v[2] = 1'b0;
        regv = v;
        wr   = 1'b1;
        gap  = 0;
      end else if (gap >= 2 && $urandom_range(0, 399) == 0) begin
        prst = 1'b1;
      end else if (gap >= 2 && $urandom_range(0, 3) == 0) begin
        regv = 8'($urandom);
      end
    end
    @(negedge clk);
    wr = 1'b0;
    prst = 1'b0;
    repeat (5) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
